// File: rtl/bc_polinomio.sv
// -----------------------------------------------------------------------------
// bc_polinomio
//
// Control block for the polynomial datapath BO. It sequences BO's mux selects,
// ALU mode and register loads so that BO evaluates
//     Pronto = (A*x + B)*x + C
// in Horner form. A start/busy/done handshake frames each computation.
//
// Each datapath step lasts STEP_CYCLES cycles. This lets BO's ALU settle
// before the step's register load is pulsed in the step's last cycle.
//
// Parameters
//   STEP_CYCLES : cycles each datapath step is held (legal range 1..15)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-low reset
//   start  in   request a computation; only sampled while idle
//   busy   out  high from the first step through the done cycle
//   done   out  one-cycle pulse; BO Pronto is valid while high
//   M0     out  BO constant mux select: 0=zero, 1=A, 2=B, 3=C
//   M1     out  BO ALU operand 1 select: 0=M0 out, 1=R0, 2=R1, 3=R2
//   M2     out  BO ALU operand 2 select: 0=R0, 1=M0 out, 2=R1, 3=R2
//   H      out  BO ALU mode: 1=multiply, 0=add
//   LX     out  BO R0 load (x)
//   LH     out  BO R1 load (temporary)
//   LS     out  BO R2 load (result)
//   n_res  out  completed-result count, wraps 255->0 (BC_CNT_EN only)
//
// Configuration macro
//   BC_CNT_EN : when defined, adds the n_res port and its counter.
//               When undefined, neither the port nor the logic exists.
//
// All outputs come straight from flops. Those flops are loaded from the
// decode of the *next* state and step count, so each output lines up with
// the state it belongs to and adds no extra cycle of latency.
// -----------------------------------------------------------------------------
module bc_polinomio #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H,
    output logic       LX,
    output logic       LH,
    output logic       LS
`ifdef BC_CNT_EN
    ,
    output logic [7:0] n_res
`endif
);

    // Step counter value in the last cycle of a step.
    localparam logic [3:0] LAST_STEP = 4'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADX = 3'd1,
        S_MULA  = 3'd2,
        S_ADDB  = 3'd3,
        S_MULX  = 3'd4,
        S_ADDC  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Complete set of registered controls presented to BO.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       lx;
        logic       lh;
        logic       ls;
    } ctl_t;

    localparam ctl_t CTL_ZERO = ctl_t'(12'd0);

    state_t     state_r;
    state_t     stateNext_s;
    logic [3:0] stepCnt_r;
    logic [3:0] stepCntNext_s;
    logic       stepLast_s;
    ctl_t       ctlNext_s;
    ctl_t       ctl_r;

    // Returns the state that follows a datapath step.
    // Illegal inputs fall back to IDLE.
    function automatic state_t followingStep(input state_t st);
        state_t nxt;
        case (st)
            S_LOADX: nxt = S_MULA;
            S_MULA:  nxt = S_ADDB;
            S_ADDB:  nxt = S_MULX;
            S_MULX:  nxt = S_ADDC;
            S_ADDC:  nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // Moore decode of the controls for a given state and step count.
    // Selects and ALU mode are held for the whole step. The step's load
    // enable fires only in its last cycle, once the ALU output has settled.
    function automatic ctl_t decodeCtl(input state_t st, input logic [3:0] cnt);
        ctl_t c;
        logic last;
        c    = CTL_ZERO;
        last = (cnt == LAST_STEP);
        case (st)
            S_IDLE: begin
                c = CTL_ZERO;
            end
            S_LOADX: begin
                c.busy = 1'b1;
                c.lx   = last;
            end
            S_MULA: begin
                c.busy = 1'b1;
                c.m0   = 2'd1;
                c.m1   = 2'd0;
                c.m2   = 2'd0;
                c.h    = 1'b1;
                c.lh   = last;
            end
            S_ADDB: begin
                c.busy = 1'b1;
                c.m0   = 2'd2;
                c.m1   = 2'd2;
                c.m2   = 2'd1;
                c.h    = 1'b0;
                c.lh   = last;
            end
            S_MULX: begin
                c.busy = 1'b1;
                c.m0   = 2'd0;
                c.m1   = 2'd2;
                c.m2   = 2'd0;
                c.h    = 1'b1;
                c.lh   = last;
            end
            S_ADDC: begin
                c.busy = 1'b1;
                c.m0   = 2'd3;
                c.m1   = 2'd2;
                c.m2   = 2'd1;
                c.h    = 1'b0;
                c.ls   = last;
            end
            S_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: begin
                c = CTL_ZERO;
            end
        endcase
        return c;
    endfunction

    assign stepLast_s = (stepCnt_r == LAST_STEP);

    // Next-state and next step-count logic.
    // The step counter restarts from zero on every state change.
    always_comb begin
        stateNext_s   = S_IDLE;
        stepCntNext_s = 4'd0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    stateNext_s = S_LOADX;
                end else begin
                    stateNext_s = S_IDLE;
                end
            end
            S_LOADX, S_MULA, S_ADDB, S_MULX, S_ADDC: begin
                if (stepLast_s) begin
                    stateNext_s   = followingStep(state_r);
                    stepCntNext_s = 4'd0;
                end else begin
                    stateNext_s   = state_r;
                    stepCntNext_s = stepCnt_r + 4'd1;
                end
            end
            S_DONE: begin
                stateNext_s = S_IDLE;
            end
            default: begin
                stateNext_s = S_IDLE;
            end
        endcase
    end

    // Decode the controls for the next cycle so the output flops track the state.
    always_comb begin
        ctlNext_s = CTL_ZERO;
        ctlNext_s = decodeCtl(stateNext_s, stepCntNext_s);
    end

    // State and step counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            stepCnt_r <= 4'd0;
        end else begin
            state_r   <= stateNext_s;
            stepCnt_r <= stepCntNext_s;
        end
    end

    // Registered control outputs.
    // Reset clears them asynchronously so BO sees no loads at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_r <= CTL_ZERO;
        end else begin
            ctl_r <= ctlNext_s;
        end
    end

    assign busy = ctl_r.busy;
    assign done = ctl_r.done;
    assign M0   = ctl_r.m0;
    assign M1   = ctl_r.m1;
    assign M2   = ctl_r.m2;
    assign H    = ctl_r.h;
    assign LX   = ctl_r.lx;
    assign LH   = ctl_r.lh;
    assign LS   = ctl_r.ls;

`ifdef BC_CNT_EN
    logic [7:0] nRes_r;

    // Completed-result counter.
    // It advances on the clock edge that ends each DONE cycle and wraps
    // naturally from 255 to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nRes_r <= 8'd0;
        end else if (state_r == S_DONE) begin
            nRes_r <= nRes_r + 8'd1;
        end else begin
            nRes_r <= nRes_r;
        end
    end

    assign n_res = nRes_r;
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// -----------------------------------------------------------------------------
// tb_bc_polinomio
//
// Drives two controllers, one with STEP_CYCLES=1 and one with STEP_CYCLES=3.
// Each controller's outputs feed a behavioural BO datapath. The bench checks
// the controls cycle by cycle against a per-step table of the expected
// sequence, and checks Pronto against A*x*x + B*x + C truncated to 16 bits.
// -----------------------------------------------------------------------------
module tb_bc_polinomio;

    logic clk;
    logic rst;
    logic start1;
    logic start3;

    logic       busy1, done1, H1, LX1, LH1, LS1;
    logic [1:0] M0_1, M1_1, M2_1;
    logic       busy3, done3, H3, LX3, LH3, LS3;
    logic [1:0] M0_3, M1_3, M2_3;
`ifdef BC_CNT_EN
    logic [7:0] nRes1, nRes3;
`endif

    int checks = 0;
    int errors = 0;

    bc_polinomio #(.STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .busy(busy1), .done(done1),
        .M0(M0_1), .M1(M1_1), .M2(M2_1),
        .H(H1), .LX(LX1), .LH(LH1), .LS(LS1)
`ifdef BC_CNT_EN
        , .n_res(nRes1)
`endif
    );

    bc_polinomio #(.STEP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .busy(busy3), .done(done3),
        .M0(M0_3), .M1(M1_3), .M2(M2_3),
        .H(H3), .LX(LX3), .LH(LH3), .LS(LS3)
`ifdef BC_CNT_EN
        , .n_res(nRes3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control observation vectors: {busy,done,M0,M1,M2,H,LX,LH,LS}
    logic [11:0] obs1, obs3;
    assign obs1 = {busy1, done1, M0_1, M1_1, M2_1, H1, LX1, LH1, LS1};
    assign obs3 = {busy3, done3, M0_3, M1_3, M2_3, H3, LX3, LH3, LS3};

    // ---------------- behavioural BO datapath ----------------
    logic [15:0] opA, opB, opC, opX;
    logic [15:0] r0, r1, r2;
    logic        boSel;
    logic [11:0] boCtl;
    logic [15:0] m0Out, alu1, alu2, aluOut;

    assign boCtl = boSel ? obs3 : obs1;

    always_comb begin
        case (boCtl[9:8])
            2'd0: m0Out = 16'd0;
            2'd1: m0Out = opA;
            2'd2: m0Out = opB;
            default: m0Out = opC;
        endcase
        case (boCtl[7:6])
            2'd0: alu1 = m0Out;
            2'd1: alu1 = r0;
            2'd2: alu1 = r1;
            default: alu1 = r2;
        endcase
        case (boCtl[5:4])
            2'd0: alu2 = r0;
            2'd1: alu2 = m0Out;
            2'd2: alu2 = r1;
            default: alu2 = r2;
        endcase
        aluOut = boCtl[3] ? (alu1 * alu2) : (alu1 + alu2);
    end

    always_ff @(posedge clk) begin
        if (boCtl[2]) r0 <= opX;
        if (boCtl[1]) r1 <= aluOut;
        if (boCtl[0]) r2 <= aluOut;
    end

    // ---------------- reference model ----------------
    // Expected controls in cycle c after start is accepted (c=1 is the first step).
    function automatic logic [11:0] expected_ctl(input int c, input int s);
        logic [11:0] v;
        int step;
        logic last;
        v = 12'd0;
        if (c >= 1 && c <= 5 * s) begin
            step  = (c - 1) / s;
            last  = (((c - 1) % s) == (s - 1));
            v[11] = 1'b1;
            case (step)
                0: v[2] = last;
                1: begin v[9:8] = 2'd1; v[7:6] = 2'd0; v[5:4] = 2'd0; v[3] = 1'b1; v[1] = last; end
                2: begin v[9:8] = 2'd2; v[7:6] = 2'd2; v[5:4] = 2'd1; v[3] = 1'b0; v[1] = last; end
                3: begin v[9:8] = 2'd0; v[7:6] = 2'd2; v[5:4] = 2'd0; v[3] = 1'b1; v[1] = last; end
                default: begin v[9:8] = 2'd3; v[7:6] = 2'd2; v[5:4] = 2'd1; v[3] = 1'b0; v[0] = last; end
            endcase
        end else if (c == 5 * s + 1) begin
            v[11] = 1'b1;
            v[10] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [15:0] poly(input logic [15:0] a, b, c, xv);
        logic [31:0] full;
        full = 32'(a) * 32'(xv) * 32'(xv) + 32'(b) * 32'(xv) + 32'(c);
        return full[15:0];
    endfunction

    // Run one computation on the selected controller and check every cycle.
    task automatic run_compute(input bit sel3, input logic [15:0] a, b, c, xv, input string name);
        int s;
        int total;
        logic [15:0] expP;
        logic [11:0] o;
        s = sel3 ? 3 : 1;
        total = 5 * s + 1;
        opA = a; opB = b; opC = c; opX = xv; boSel = sel3;
        expP = poly(a, b, c, xv);
        @(posedge clk); #1;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        for (int cy = 1; cy <= total + 1; cy++) begin
            o = sel3 ? obs3 : obs1;
            checks++;
            if (o !== expected_ctl(cy, s)) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got %h expected %h", name, cy, o, expected_ctl(cy, s));
            end
            if (cy == total) begin
                checks++;
                if (r2 !== expP) begin
                    errors++;
                    $display("FAIL %s pronto: got %0d expected %0d", name, r2, expP);
                end
            end
            if (cy <= total) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start1 = 1'b0; start3 = 1'b0; boSel = 1'b0;
        opA = 16'd0; opB = 16'd0; opC = 16'd0; opX = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs1 !== 12'd0 || obs3 !== 12'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h/%h expected 000/000", obs1, obs3);
        end
`ifdef BC_CNT_EN
        checks++;
        if (nRes1 !== 8'd0) begin
            errors++;
            $display("FAIL reset n_res: got %0d expected 0", nRes1);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_compute(1'b0, 16'd1, 16'd2, 16'd3, 16'd2, "basic");
        run_compute(1'b0, 16'd5, 16'd7, 16'd9, 16'd0, "x_zero");
    endtask

    task automatic test_step3();
        run_compute(1'b1, 16'd2, 16'd0, 16'd1, 16'd3, "step3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_compute(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
                        16'($urandom()), 16'($urandom()), "random");
        end
    endtask

    // Start pulses during MULA and DONE must be ignored.
    task automatic test_ignore_start();
        int dones;
        int doneAt;
        logic expBusy;
        dones = 0; doneAt = -1; boSel = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1;
        for (int cy = 1; cy <= 12; cy++) begin
            @(posedge clk); #1;
            expBusy = (cy >= 1 && cy <= 6);
            checks++;
            if (busy1 !== expBusy) begin
                errors++;
                $display("FAIL ignore busy cycle %0d: got %b expected %b", cy, busy1, expBusy);
            end
            if (done1 === 1'b1) begin
                dones++;
                doneAt = cy;
            end
            start1 = (cy == 2 || cy == 6);
        end
        start1 = 1'b0;
        checks++;
        if (dones != 1 || doneAt != 6) begin
            errors++;
            $display("FAIL ignore done: got %0d pulses at %0d expected 1 at 6", dones, doneAt);
        end
    endtask

    // Asynchronous reset in MULX, then a full correct sequence.
    task automatic test_reset_mid();
        boSel = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs1 !== expected_ctl(4, 1)) begin
            errors++;
            $display("FAIL reset_mid pre: got %h expected %h", obs1, expected_ctl(4, 1));
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs1 !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid async: got %h expected 000", obs1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_compute(1'b0, 16'd3, 16'd4, 16'd5, 16'd6, "after_reset");
    endtask

    // start held high: a new run begins every 5*S+2 cycles.
    task automatic test_back_to_back(input bit sel3);
        int s;
        int period;
        logic [15:0] expP;
        logic [11:0] o;
        s = sel3 ? 3 : 1;
        period = 5 * s + 2;
        opA = 16'($urandom()); opB = 16'($urandom()); opC = 16'($urandom()); opX = 16'($urandom());
        boSel = sel3;
        expP = poly(opA, opB, opC, opX);
        @(posedge clk); #1;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        for (int cy = 1; cy <= 2 * period; cy++) begin
            @(posedge clk); #1;
            o = sel3 ? obs3 : obs1;
            checks++;
            if (o !== expected_ctl(((cy - 1) % period) + 1, s)) begin
                errors++;
                $display("FAIL b2b ctl cycle %0d: got %h expected %h", cy, o, expected_ctl(((cy - 1) % period) + 1, s));
            end
            if (((cy - 1) % period) + 1 == 5 * s + 1) begin
                checks++;
                if (r2 !== expP) begin
                    errors++;
                    $display("FAIL b2b pronto: got %0d expected %0d", r2, expP);
                end
            end
            if (cy == 2 * period) begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
        end
    endtask

`ifdef BC_CNT_EN
    // 257 results wrap the 8-bit count to 1.
    task automatic test_counter();
        int dones;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        dones = 0;
        start1 = 1'b1;
        for (int cy = 0; cy < 257 * 7 + 20 && dones < 257; cy++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) dones++;
            if (dones == 257) start1 = 1'b0;
        end
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dones != 257 || nRes1 !== 8'd1) begin
            errors++;
            $display("FAIL counter: got %0d runs n_res %0d expected 257 runs n_res 1", dones, nRes1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_step3();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
`ifdef BC_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
